// File: rtl/midi_pkg.sv
// Shared MIDI receive-path definitions: line rate, receiver FSM states, status-byte mask.
// Also holds the 2-of-3 vote used when MIDI_RX_MAJORITY_EN is defined.
package midi_pkg;

   localparam int         MIDI_BAUD        = 31_250;
   localparam logic [7:0] MIDI_STATUS_MASK = 8'h80;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLK_FREQ_HZ/(BAUD*OVERSAMPLE) clocks.
// restart reloads the divider so the tick phase lines up with an external event.
module baud_tick_gen #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 31_250,
   parameter int OVERSAMPLE  = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
   localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (restart || cnt == '0)
         cnt <= CW'(TICK_DIV - 1);
      else
         cnt <= cnt - 1'b1;
   end

   // First tick after a restart lands exactly TICK_DIV clocks later.
   assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 UART receiver: emits a one-cycle ready strobe with MIDIbyte per good frame.
// Define MIDI_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = MIDI_BAUD,
   parameter int OVERSAMPLE  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       ready,
   output logic [7:0] MIDIbyte,
   output logic       framing_error
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] BIT_DEC = TW'(OVERSAMPLE - 1);
`ifdef MIDI_RX_MAJORITY_EN
   localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2);
`else
   localparam logic [TW-1:0] START_DEC = TW'(OVERSAMPLE / 2 - 1);
`endif

   logic [1:0]    sync;
   logic          rx_s, tick, restart, smp;
   rx_state_t     state, state_n;
   logic [TW-1:0] tick_cnt, tick_cnt_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n, byte_n;
   logic          ready_n, fe_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= 2'b11;
      else        sync <= {sync[0], rx};
   end
   assign rx_s = sync[1];

   baud_tick_gen #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD),
      .OVERSAMPLE  (OVERSAMPLE)
   ) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

`ifdef MIDI_RX_MAJORITY_EN
   // Last two tick samples; with the current one they cover centre-1..centre+1.
   logic [1:0] hist;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    hist <= 2'b11;
      else if (tick) hist <= {hist[0], rx_s};
   end
   assign smp = maj3(hist[1], hist[0], rx_s);
`else
   assign smp = rx_s;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         MIDIbyte      <= '0;
         ready         <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         state         <= state_n;
         tick_cnt      <= tick_cnt_n;
         bit_cnt       <= bit_cnt_n;
         shreg         <= shreg_n;
         MIDIbyte      <= byte_n;
         ready         <= ready_n;
         framing_error <= fe_n;
      end
   end

   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      byte_n     = MIDIbyte;
      ready_n    = 1'b0;
      fe_n       = 1'b0;
      restart    = 1'b0;
      case (state)
         IDLE: if (!rx_s) begin
            state_n    = START;
            tick_cnt_n = '0;
            restart    = 1'b1;
         end
         START: if (tick) begin
            if (tick_cnt == START_DEC) begin
               if (!smp) begin
                  state_n    = DATA;
                  tick_cnt_n = '0;
                  bit_cnt_n  = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               tick_cnt_n = tick_cnt + 1'b1;
            end
         end
         DATA: if (tick) begin
            if (tick_cnt == BIT_DEC) begin
               shreg_n    = {smp, shreg[7:1]};
               tick_cnt_n = '0;
               if (bit_cnt == 3'd7) state_n = STOP;
               else                 bit_cnt_n = bit_cnt + 1'b1;
            end else begin
               tick_cnt_n = tick_cnt + 1'b1;
            end
         end
         STOP: if (tick) begin
            if (tick_cnt == BIT_DEC) begin
               if (smp) begin
                  byte_n  = shreg;
                  ready_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  fe_n    = 1'b1;
                  state_n = WAIT_HIGH;
               end
            end else begin
               tick_cnt_n = tick_cnt + 1'b1;
            end
         end
         WAIT_HIGH: if (rx_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_midi_uart_rx.sv
// Randomised self-checking bench for midi_uart_rx against an event-queue reference model.
module tb_midi_uart_rx;

   localparam int OS    = 16;
   localparam int TD    = 5;
   localparam int CLKHZ = 31_250 * OS * TD;
   localparam int BITC  = TD * OS;
`ifdef MIDI_RX_MAJORITY_EN
   localparam int NDEC = OS / 2 + 1 + 9 * OS;
`else
   localparam int NDEC = OS / 2 + 9 * OS;
`endif
   // Start edge -> 2 sync flops -> restart cycle -> NDEC ticks -> registered strobe.
   localparam int LAT = 3 + NDEC * TD;

   logic       clk, reset, rx;
   logic       ready, framing_error;
   logic [7:0] MIDIbyte;

   midi_uart_rx #(.CLK_FREQ_HZ(CLKHZ), .BAUD(31_250), .OVERSAMPLE(OS)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx            (rx),
      .ready         (ready),
      .MIDIbyte      (MIDIbyte),
      .framing_error (framing_error)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         fe;
      logic [7:0] d;
      int         t;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         n_cmp = 0, n_bad = 0;
   bit         prev_any = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset && (ready || framing_error)) begin
         chk("pulse_width", int'(prev_any), 0);
         chk("exclusive", int'(ready & framing_error), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("strobe_kind", int'(framing_error), int'(e.fe));
            chk("midibyte", int'(MIDIbyte), int'(e.d));
            chk("latency", cyc - e.t, LAT);
         end
      end
      prev_any <= ready | framing_error;
   end

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      ev_t e;
      if (stop_ok) last_good = b;
      e.fe = !stop_ok;
      e.d  = last_good;
      e.t  = cyc;
      exp_q.push_back(e);
      rx = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BITC) @(negedge clk);
      end
      rx = stop_ok;
      repeat (BITC) @(negedge clk);
      if (!stop_ok) idle(BITC);
   endtask

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: cycle budget exhausted, %0d events pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b7f;
      reset = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_ready", int'(ready), 0);
      chk("rst_fe", int'(framing_error), 0);
      chk("rst_byte", int'(MIDIbyte), 0);
      reset = 1'b1;
      idle(3);

      send_frame(8'h90, 1'b1);
      idle(BITC);
      send_frame(8'h90, 1'b1);
      send_frame(8'h3C, 1'b1);
      send_frame(8'h64, 1'b1);
      idle(BITC);

      // Glitch shorter than half a bit must be rejected silently.
      rx = 1'b0;
      repeat (BITC / 4) @(negedge clk);
      idle(2 * BITC);

      send_frame(8'h45, 1'b0);
      idle(BITC);
      send_frame(8'h80, 1'b1);
      idle(BITC);

      // Break: a long low line yields exactly one framing error.
      begin
         ev_t e;
         e.fe = 1'b1; e.d = last_good; e.t = cyc;
         exp_q.push_back(e);
         rx = 1'b0;
         repeat (30 * BITC) @(negedge clk);
         idle(2 * BITC);
      end
      send_frame(8'hB0, 1'b1);
      idle(BITC);

      // Reset in the middle of bit 4 of 0x7F; the aborted frame must vanish.
      b7f = 8'h7F;
      rx = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b7f[i];
         if (i == 4) begin
            repeat (BITC / 2) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            chk("midrst_ready", int'(ready), 0);
            chk("midrst_fe", int'(framing_error), 0);
            chk("midrst_byte", int'(MIDIbyte), 0);
            repeat (BITC / 2 - 1) @(negedge clk);
         end else begin
            repeat (BITC) @(negedge clk);
         end
      end
      idle(BITC);
      last_good = 8'h00;
      reset = 1'b1;
      idle(BITC);
      send_frame(8'h12, 1'b1);

      for (int n = 0; n < 36; n++) begin
         logic [7:0] rb;
         bit ok;
         rb = 8'($urandom);
         ok = ($urandom_range(0, 7) != 0);
         send_frame(rb, ok);
         if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2 * BITC));
      end

      idle(2 * BITC);
      chk("pending_events", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
